// File: rtl/mux_serial_ctrl_pkg.sv
// Shared definitions for the 7-bit serializing mux sequencer:
// state encodings and the select value that parks the mux.
package mux_serial_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic [2:0] SEL_IDLE = 3'b111;
   localparam logic [2:0] SEL_LAST = 3'd6;

endpackage

// File: rtl/mux_serial_ctrl_if.sv
// Control/data bundle between the sequencer and its driving logic.
interface mux_serial_ctrl_if;
   logic       Start;
   logic       Abort;
   logic [6:0] Data;
   logic [2:0] MuxSelect;
   logic       SerialOut;
   logic       BitValid;
   logic       Busy;
   logic       Done;

   modport master (
      output Start, Abort, Data,
      input  MuxSelect, SerialOut, BitValid, Busy, Done
   );

   modport slave (
      input  Start, Abort, Data,
      output MuxSelect, SerialOut, BitValid, Busy, Done
   );
endinterface

// File: rtl/mux_serial_ctrl_mux7_sel.sv
// Combinational 7:1 bit select; select 3'b111 parks the output low.
module mux7_sel
   import mux_serial_ctrl_pkg::*;
(
   input  logic [6:0] data,
   input  logic [2:0] sel,
   output logic       bit_o
);

   always_comb begin
      bit_o = 1'b0;
      case (sel)
         3'd0:    bit_o = data[0];
         3'd1:    bit_o = data[1];
         3'd2:    bit_o = data[2];
         3'd3:    bit_o = data[3];
         3'd4:    bit_o = data[4];
         3'd5:    bit_o = data[5];
         3'd6:    bit_o = data[6];
         default: bit_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/mux_serial_ctrl.sv
// Sequencer that captures a 7-bit word on Start and walks the mux select
// 0..6, holding each bit for HOLD_CYCLES clocks, LSB first.
module mux_serial_ctrl
   import mux_serial_ctrl_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   mux_serial_ctrl_if.slave bus
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_e     state_q, state_d;
   logic [6:0] data_q, data_d;
   logic [7:0] hold_q, hold_d;
   logic [2:0] sel_q, sel_d;
   logic       serial_out;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         hold_q  <= '0;
         sel_q   <= SEL_IDLE;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         hold_q  <= hold_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      hold_d  = hold_q;
      sel_d   = sel_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.Start) begin
               state_d = ST_SHIFT;
               data_d  = bus.Data;
               hold_d  = '0;
               sel_d   = '0;
            end
         end
         ST_SHIFT: begin
            // Abort wins over the end-of-hold step, including on the last bit.
            if (bus.Abort) begin
               state_d = ST_IDLE;
               hold_d  = '0;
               sel_d   = SEL_IDLE;
            end else if (hold_q == HOLD_LAST) begin
               hold_d = '0;
               if (sel_q == SEL_LAST) begin
                  state_d = ST_DONE;
                  sel_d   = SEL_IDLE;
               end else begin
                  sel_d = sel_q + 3'd1;
               end
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = SEL_IDLE;
         end
      endcase
   end

   mux7_sel u_mux7_sel (
      .data  (data_q),
      .sel   (sel_q),
      .bit_o (serial_out)
   );

   assign bus.MuxSelect = sel_q;
   assign bus.SerialOut = serial_out;
   assign bus.BitValid  = (state_q == ST_SHIFT);
   assign bus.Busy      = (state_q == ST_SHIFT);
   assign bus.Done      = (state_q == ST_DONE);

endmodule
